// File: rtl/fcvt_pkg.sv
// Shared types and constants for the conversion scheduler: request/result payloads
// and OpCtrl bit positions.
package fcvt_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned FLEN    = 64;
    localparam int unsigned FMTBITS = 2;
    localparam int unsigned TAGW    = 5;
    localparam int unsigned FLGW    = 5;
    localparam int unsigned OPW     = 3;

    localparam int unsigned SIGNED_B  = 0;
    localparam int unsigned INT64_B   = 1;
    localparam int unsigned INTTOFP_B = 2;

    localparam logic SRC_FPU = 1'b0;
    localparam logic SRC_IEU = 1'b1;

    typedef struct packed {
        logic [OPW-1:0]     op;
        logic [FMTBITS-1:0] fmt;
        logic [FLEN-1:0]    x;
        logic [XLEN-1:0]    ival;
        logic [TAGW-1:0]    tag;
        logic               src;
    } cvt_req_t;

    typedef struct packed {
        logic [FLEN-1:0] data;
        logic [FLGW-1:0] flg;
        logic [TAGW-1:0] tag;
        logic            to_int;
    } cvt_res_t;

    // fp->fp is encoded as OpCtrl 000 on the FPU port; any other fp-source op targets the int RF
    function automatic logic is_to_int(input cvt_req_t r);
        return (r.src == SRC_FPU) && !r.op[INTTOFP_B] && (r.op[SIGNED_B] || r.op[INT64_B]);
    endfunction

endpackage

// File: rtl/fcvt_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred port and moves to
// the loser of every grant that is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_c = req;
        ptr_d = ptr_q;
        if (&req) begin
            gnt_c = ptr_q ? 2'b10 : 2'b01;
        end
        if (en && (|req)) begin
            ptr_d = gnt_c[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fcvt_sched.sv
// Scheduler for the shared conversion datapath: arbitrates FPU/IEU requests into
// S1 (drives datapath), captures the result into S2 and hands it to writeback.
module fcvt_sched
    import fcvt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               Req0Valid,
    output logic               Req0Ready,
    input  logic [OPW-1:0]     Req0Op,
    input  logic [FMTBITS-1:0] Req0Fmt,
    input  logic [FLEN-1:0]    Req0X,
    input  logic [TAGW-1:0]    Req0Tag,
    input  logic               Req1Valid,
    output logic               Req1Ready,
    input  logic [OPW-1:0]     Req1Op,
    input  logic [FMTBITS-1:0] Req1Fmt,
    input  logic [XLEN-1:0]    Req1Int,
    input  logic [TAGW-1:0]    Req1Tag,
    input  logic               Flush,
    output logic [OPW-1:0]     DpOpCtrl,
    output logic [FMTBITS-1:0] DpFmt,
    output logic               DpToInt,
    output logic [FLEN-1:0]    DpX,
    output logic [XLEN-1:0]    DpInt,
    input  logic [FLEN-1:0]    DpRes,
    input  logic [FLGW-1:0]    DpFlg,
    output logic               ResValid,
    input  logic               ResReady,
    output logic [FLEN-1:0]    ResData,
    output logic [FLGW-1:0]    ResFlg,
    output logic [TAGW-1:0]    ResTag,
    output logic               ResToInt,
    output logic               Busy
);

    cvt_req_t   s1_q, s1_d, new_req_c;
    cvt_res_t   s2_q, s2_d;
    logic       s1v_q, s1v_d, s2v_q, s2v_d;
    logic       adv1_c, adv2_c, acc_c;
    logic [1:0] gnt_c;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({Req1Valid, Req0Valid}),
        .en    (adv1_c & ~Flush),
        .gnt_c (gnt_c)
    );

    always_comb begin
        adv2_c    = ~s2v_q | ResReady;
        adv1_c    = ~s1v_q | adv2_c;
        Req0Ready = adv1_c & gnt_c[0] & ~Flush;
        Req1Ready = adv1_c & gnt_c[1] & ~Flush;
        acc_c     = Req0Ready | Req1Ready;

        // Unused operand field is zeroed so the datapath never sees stale or X data
        new_req_c = '0;
        if (gnt_c[1]) begin
            new_req_c.op   = Req1Op;
            new_req_c.fmt  = Req1Fmt;
            new_req_c.ival = Req1Int;
            new_req_c.tag  = Req1Tag;
            new_req_c.src  = SRC_IEU;
        end else begin
            new_req_c.op   = Req0Op;
            new_req_c.fmt  = Req0Fmt;
            new_req_c.x    = Req0X;
            new_req_c.tag  = Req0Tag;
            new_req_c.src  = SRC_FPU;
        end

        s1_d  = s1_q;
        s1v_d = s1v_q;
        s2_d  = s2_q;
        s2v_d = s2v_q;
        if (Flush) begin
            s1v_d = 1'b0;
            s2v_d = 1'b0;
            s1_d  = '0;
            s2_d  = '0;
        end else begin
            if (adv2_c) begin
                s2v_d = s1v_q;
                if (s1v_q) begin
                    s2_d.data   = DpRes;
                    s2_d.flg    = DpFlg;
                    s2_d.tag    = s1_q.tag;
                    s2_d.to_int = is_to_int(s1_q);
                end
            end
            if (adv1_c) begin
                s1v_d = acc_c;
                if (acc_c) begin
                    s1_d = new_req_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s1v_q <= 1'b0;
            s2v_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s1v_q <= s1v_d;
            s2v_q <= s2v_d;
        end
    end

    assign DpOpCtrl = s1_q.op;
    assign DpFmt    = s1_q.fmt;
    assign DpX      = s1_q.x;
    assign DpInt    = s1_q.ival;
    assign DpToInt  = is_to_int(s1_q);
    assign ResValid = s2v_q;
    assign ResData  = s2_q.data;
    assign ResFlg   = s2_q.flg;
    assign ResTag   = s2_q.tag;
    assign ResToInt = s2_q.to_int;
    assign Busy     = s1v_q | s2v_q;

endmodule

// File: tb/tb_fcvt_sched.sv
// Bench for fcvt_sched: transaction-level pipeline model checked every cycle plus
// directed cases with hand-computed literals.
module tb_fcvt_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req0Valid, Req0Ready;
    logic [2:0]  Req0Op;
    logic [1:0]  Req0Fmt;
    logic [63:0] Req0X;
    logic [4:0]  Req0Tag;
    logic        Req1Valid, Req1Ready;
    logic [2:0]  Req1Op;
    logic [1:0]  Req1Fmt;
    logic [63:0] Req1Int;
    logic [4:0]  Req1Tag;
    logic        Flush;
    logic [2:0]  DpOpCtrl;
    logic [1:0]  DpFmt;
    logic        DpToInt;
    logic [63:0] DpX, DpInt, DpRes;
    logic [4:0]  DpFlg;
    logic        ResValid, ResReady;
    logic [63:0] ResData;
    logic [4:0]  ResFlg, ResTag;
    logic        ResToInt, Busy;

    fcvt_sched dut (
        .clk(clk), .reset(reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op(Req0Op), .Req0Fmt(Req0Fmt),
        .Req0X(Req0X), .Req0Tag(Req0Tag),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op(Req1Op), .Req1Fmt(Req1Fmt),
        .Req1Int(Req1Int), .Req1Tag(Req1Tag),
        .Flush(Flush),
        .DpOpCtrl(DpOpCtrl), .DpFmt(DpFmt), .DpToInt(DpToInt), .DpX(DpX), .DpInt(DpInt),
        .DpRes(DpRes), .DpFlg(DpFlg),
        .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData), .ResFlg(ResFlg),
        .ResTag(ResTag), .ResToInt(ResToInt), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: any deterministic function of the S1 operands will do
    assign DpRes = DpX ^ DpInt ^ {59'b0, DpFmt, DpOpCtrl};
    assign DpFlg = {DpToInt, DpFmt, DpOpCtrl[1:0]};

    int nvec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] x;
        logic [63:0] ival;
        logic [2:0]  op;
        logic [1:0]  fmt;
        logic [4:0]  tag;
        bit          src;
        bit          done;
    } txn_t;

    txn_t pipe[$];
    txn_t dp;
    bit   dp_known = 1'b0;
    bit   model_ok = 1'b0;
    int   pref = 0;

    function automatic bit m_to_int(input txn_t t);
        return (t.src == 1'b0) && (t.op != 3'b000);
    endfunction

    function automatic logic [63:0] m_data(input txn_t t);
        return t.x ^ t.ival ^ {59'b0, t.fmt, t.op};
    endfunction

    function automatic logic [4:0] m_flg(input txn_t t);
        return {m_to_int(t), t.fmt, t.op[1:0]};
    endfunction

    // Model: ordered list of in-flight ops; 'done' marks an op sitting in the result slot
    always @(negedge clk) begin
        int   n, win;
        bit   head_done, s1p, adv1, adv2, r0, r1;
        txn_t t;
        n         = pipe.size();
        head_done = (n > 0) && pipe[0].done;
        s1p       = (n > 0) && !pipe[n-1].done;
        adv2      = !head_done || ResReady;
        adv1      = !s1p || adv2;
        win = -1;
        if (Req0Valid && Req1Valid) win = pref;
        else if (Req0Valid)         win = 0;
        else if (Req1Valid)         win = 1;
        r0 = adv1 && !Flush && (win == 0);
        r1 = adv1 && !Flush && (win == 1);

        if (model_ok) begin
            chk("req0_ready", 64'(Req0Ready), 64'(r0));
            chk("req1_ready", 64'(Req1Ready), 64'(r1));
            chk("res_valid", 64'(ResValid), 64'(head_done));
            chk("busy", 64'(Busy), 64'(n > 0));
            if (head_done) begin
                chk("res_tag", 64'(ResTag), 64'(pipe[0].tag));
                chk("res_data", ResData, m_data(pipe[0]));
                chk("res_flg", 64'(ResFlg), 64'(m_flg(pipe[0])));
                chk("res_toint", 64'(ResToInt), 64'(m_to_int(pipe[0])));
            end
            if (dp_known) begin
                chk("dp_op", 64'(DpOpCtrl), 64'(dp.op));
                chk("dp_fmt", 64'(DpFmt), 64'(dp.fmt));
                chk("dp_x", DpX, dp.x);
                chk("dp_int", DpInt, dp.ival);
                chk("dp_toint", 64'(DpToInt), 64'(m_to_int(dp)));
            end
        end

        if (reset) begin
            pipe.delete();
            pref     = 0;
            dp       = '{default: '0};
            dp_known = 1'b1;
            model_ok = 1'b1;
        end else if (Flush) begin
            pipe.delete();
            dp_known = 1'b0;
        end else if (model_ok) begin
            if (head_done && ResReady) void'(pipe.pop_front());
            if (adv2 && (pipe.size() > 0) && !pipe[pipe.size()-1].done)
                pipe[pipe.size()-1].done = 1'b1;
            if (r0 || r1) begin
                t.op   = r0 ? Req0Op  : Req1Op;
                t.fmt  = r0 ? Req0Fmt : Req1Fmt;
                t.x    = r0 ? Req0X   : 64'h0;
                t.ival = r0 ? 64'h0   : Req1Int;
                t.tag  = r0 ? Req0Tag : Req1Tag;
                t.src  = r1;
                t.done = 1'b0;
                pipe.push_back(t);
                dp       = t;
                dp_known = 1'b1;
                pref     = 1 - win;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        Flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic set_r0(input logic [2:0] op, input logic [1:0] fmt, input logic [63:0] x,
                          input logic [4:0] tag);
        Req0Valid = 1'b1; Req0Op = op; Req0Fmt = fmt; Req0X = x; Req0Tag = tag;
    endtask

    task automatic set_r1(input logic [2:0] op, input logic [1:0] fmt, input logic [63:0] iv,
                          input logic [4:0] tag);
        Req1Valid = 1'b1; Req1Op = op; Req1Fmt = fmt; Req1Int = iv; Req1Tag = tag;
    endtask

    initial begin
        reset = 1'b1; ResReady = 1'b1; idle();
        Req0Op = '0; Req0Fmt = '0; Req0X = '0; Req0Tag = '0;
        Req1Op = '0; Req1Fmt = '0; Req1Int = '0; Req1Tag = '0;
        repeat (2) cyc();
        @(negedge clk);
        chk("reset_busy", 64'(Busy), 64'h0);
        chk("reset_dpx", DpX, 64'h0);

        // Directed fp->int op: accept cycle 0, result cycle 2
        cyc();
        reset = 1'b0;
        set_r0(3'b001, 2'b00, 64'h3FF0000000000000, 5'd3);
        @(negedge clk);
        chk("c0_req0_ready", 64'(Req0Ready), 64'h1);
        cyc(); idle();
        @(negedge clk);
        chk("c1_res_valid", 64'(ResValid), 64'h0);
        cyc();
        @(negedge clk);
        chk("c2_res_valid", 64'(ResValid), 64'h1);
        chk("c2_res_tag", 64'(ResTag), 64'd3);
        chk("c2_res_data", ResData, 64'h3FF0000000000001);
        chk("c2_res_toint", 64'(ResToInt), 64'h1);
        cyc(); cyc();

        // Both ports contending: grants alternate starting at port 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_r0(3'b010, 2'b01, 64'(k) << 8, 5'(10 + 2 * k));
            set_r1(3'b101, 2'b00, 64'(k) + 64'h100, 5'(11 + 2 * k));
            @(negedge clk);
            chk("rr_req0_ready", 64'(Req0Ready), 64'((k % 2) == 0));
            chk("rr_req1_ready", 64'(Req1Ready), 64'((k % 2) == 1));
            cyc();
        end
        idle();
        repeat (4) cyc();

        // Backpressure: two ops fill S1/S2, result held while writeback stalls
        do_reset();
        ResReady = 1'b0;
        set_r0(3'b011, 2'b01, 64'h4000000000000000, 5'd20);
        set_r1(3'b110, 2'b10, 64'h55, 5'd21);
        cyc(); cyc();
        @(negedge clk);
        chk("full_req0_ready", 64'(Req0Ready), 64'h0);
        chk("full_req1_ready", 64'(Req1Ready), 64'h0);
        idle();
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            chk("stall_valid", 64'(ResValid), 64'h1);
            chk("stall_data", ResData, 64'h400000000000000B);
        end
        ResReady = 1'b1;
        repeat (4) cyc();

        // Flush with both stages full and a pending IEU request
        do_reset();
        ResReady = 1'b0;
        set_r0(3'b001, 2'b00, 64'h7, 5'd1);
        set_r1(3'b100, 2'b00, 64'h9, 5'd2);
        cyc(); cyc();
        Req0Valid = 1'b0;
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_req1_ready", 64'(Req1Ready), 64'h0);
        cyc(); idle(); ResReady = 1'b1;
        @(negedge clk);
        chk("flush_res_valid", 64'(ResValid), 64'h0);
        chk("flush_busy", 64'(Busy), 64'h0);

        // Reset while S2 is stalled
        ResReady = 1'b0;
        set_r0(3'b011, 2'b11, 64'hABCD, 5'd5);
        set_r1(3'b111, 2'b01, 64'h1234, 5'd6);
        cyc(); cyc(); cyc();
        idle(); reset = 1'b1;
        cyc(); reset = 1'b0; ResReady = 1'b1;
        set_r0(3'b001, 2'b00, 64'h1, 5'd7);
        set_r1(3'b100, 2'b00, 64'h2, 5'd8);
        @(negedge clk);
        chk("rst_res_valid", 64'(ResValid), 64'h0);
        chk("rst_dpx", DpX, 64'h0);
        chk("rst_dpint", DpInt, 64'h0);
        chk("rst_dpop", 64'(DpOpCtrl), 64'h0);
        chk("rst_req0_ready", 64'(Req0Ready), 64'h1);
        chk("rst_req1_ready", 64'(Req1Ready), 64'h0);
        cyc(); idle();
        repeat (3) cyc();

        // Operand zeroing per source
        set_r1(3'b111, 2'b10, 64'hFFFFFFFFFFFFFFFF, 5'd9);
        cyc(); idle();
        @(negedge clk);
        chk("ieu_dpx", DpX, 64'h0);
        chk("ieu_dpint", DpInt, 64'hFFFFFFFFFFFFFFFF);
        chk("ieu_dptoint", 64'(DpToInt), 64'h0);
        set_r0(3'b000, 2'b01, 64'h123, 5'd10);
        cyc(); idle();
        @(negedge clk);
        chk("fpu_dpint", DpInt, 64'h0);
        chk("fpu_dpx", DpX, 64'h123);
        chk("fpu_dptoint", 64'(DpToInt), 64'h0);
        repeat (3) cyc();

        // Mixed traffic with random backpressure and occasional flush
        for (int k = 0; k < 80; k++) begin
            Req0Valid = 1'($urandom_range(0, 1));
            Req0Op    = {1'b0, 2'($urandom)};
            Req0Fmt   = 2'($urandom);
            Req0X     = {32'($urandom), 32'($urandom)};
            Req0Tag   = 5'($urandom);
            Req1Valid = 1'($urandom_range(0, 1));
            Req1Op    = {1'b1, 2'($urandom)};
            Req1Fmt   = 2'($urandom);
            Req1Int   = {32'($urandom), 32'($urandom)};
            Req1Tag   = 5'($urandom);
            ResReady  = ($urandom_range(0, 3) != 0);
            Flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle(); ResReady = 1'b1;
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
